// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: sequencer states and default operand width.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

    localparam int unsigned ARITH_W = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit needs a borrow.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (a - b - borrow_in), LSB first, one bit per clock,
// with valid/ready handshakes on operand and result sides.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned W = ARITH_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         borrow_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow_out,
    output logic         ovf,
    output logic         busy
);

    localparam int unsigned    CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    sub_state_t    state;
    sub_state_t    state_nxt;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  diff_r;
    logic [CW-1:0] cnt;
    logic          brw;
    logic          a_msb;
    logic          b_msb;
    logic          ovf_r;
    logic          cell_d;
    logic          cell_bout;

    full_subtractor u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = RUN;
            RUN:     if (cnt == LAST)  state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_sr   <= '0;
            b_sr   <= '0;
            diff_r <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= borrow_in;
                        a_msb <= a[W-1];
                        b_msb <= b[W-1];
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    diff_r <= W'({cell_d, diff_r} >> 1);
                    brw    <= cell_bout;
                    cnt    <= cnt + 1'b1;
                    // On the last bit cell_d is the final diff MSB, so overflow
                    // is resolved here rather than from the diff register.
                    if (cnt == LAST) begin
                        ovf_r <= (a_msb != b_msb) && (cell_d != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign diff       = diff_r;
    assign borrow_out = brw;
    assign ovf        = ovf_r;

endmodule
